// File: rtl/pipe_stage_argmax_seq_if.sv
// rtl/pipe_stage_argmax_seq_if.sv - input/output beat streams of the argmax stage sequencer
interface pipe_stage_argmax_seq_if #(
  parameter int LANES   = 2,
  parameter int WIDTH   = 16,
  parameter int ID_W    = 16,
  parameter int STAGE_W = 3
);
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [LANES*WIDTH-1:0] value_i;
  logic [LANES*ID_W-1:0]  pos_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [LANES*WIDTH-1:0] value_o;
  logic [LANES*ID_W-1:0]  result_id_o;
  logic [LANES*WIDTH-1:0] result_max_o;
  logic [STAGE_W-1:0]     beat_stage_o;

  modport master (
    output in_valid_i, value_i, pos_i, out_ready_i,
    input  in_ready_o, out_valid_o, value_o, result_id_o, result_max_o, beat_stage_o
  );

  modport slave (
    input  in_valid_i, value_i, pos_i, out_ready_i,
    output in_ready_o, out_valid_o, value_o, result_id_o, result_max_o, beat_stage_o
  );
endinterface

// File: rtl/pipe_stage_argmax_seq.sv
// rtl/pipe_stage_argmax_seq.sv - beat-counting stage sequencer with per-lane fp16 argmax and threshold select
module pipe_stage_argmax_seq #(
  parameter int                    NUM_STAGES   = 8,
  parameter int                    STEP_W       = 16,
  parameter int                    LANES        = 2,
  parameter int                    WIDTH        = 16,
  parameter int                    ID_W         = 16,
  parameter int                    NULL_ID      = 4096,
  parameter logic [15:0]           THRESH       = 16'h3BD7,
  parameter int                    ARGMAX_STAGE = 5,
  parameter int                    SELECT_STAGE = 6,
  parameter logic [NUM_STAGES-1:0] MODE_MASK    = 8'b1111_1101,
  localparam int                   SW           = $clog2(NUM_STAGES)
) (
  input  logic                             CLK_i,
  input  logic                             RST_i,
  input  logic                             stall_i,
  input  logic [(NUM_STAGES-1)*STEP_W-1:0] stage_boundary_i,
  pipe_stage_argmax_seq_if.slave           bus,
  output logic [SW-1:0]                    stage_o,
  output logic                             mode_o,
  output logic                             finished_o
);

  localparam logic [15:0]     NEG_INF = 16'hFC00;
  localparam logic [15:0]     FP_ONE  = 16'h3C00;
  localparam logic [ID_W-1:0] NULL_V  = ID_W'(NULL_ID);

  logic [STEP_W-1:0] step;
  logic [SW-1:0]     stage_next;
  logic              accept;
  logic [WIDTH-1:0]  run_max [LANES];
  logic [ID_W-1:0]   run_id  [LANES];
  logic [WIDTH-1:0]  nxt_max [LANES];
  logic [ID_W-1:0]   nxt_id  [LANES];
  logic [LANES*WIDTH-1:0] res_max_d;
  logic [LANES*ID_W-1:0]  res_id_d;

  // NaN never orders; signed zeros are equal; otherwise sign-magnitude.
  function automatic logic fp_gt(input logic [15:0] a, input logic [15:0] b);
    logic a_nan;
    logic b_nan;
    a_nan = (&a[14:10]) && (|a[9:0]);
    b_nan = (&b[14:10]) && (|b[9:0]);
    if (a_nan || b_nan) return 1'b0;
    if (a[14:0] == 15'd0 && b[14:0] == 15'd0) return 1'b0;
    if (a[15] != b[15]) return b[15];
    if (!a[15]) return a[14:0] > b[14:0];
    return a[14:0] < b[14:0];
  endfunction

  assign bus.in_ready_o = !stall_i && (!bus.out_valid_o || bus.out_ready_i);
  assign accept         = bus.in_valid_i && bus.in_ready_o;
  assign finished_o     = (stage_o == SW'(NUM_STAGES-1));
  assign mode_o         = MODE_MASK[stage_o];

  // Count of exceeded boundaries; at most NUM_STAGES-1, so the cap is implicit.
  always_comb begin
    stage_next = '0;
    for (int k = 0; k < NUM_STAGES-1; k++) begin
      if (step > stage_boundary_i[k*STEP_W +: STEP_W]) stage_next = stage_next + 1'b1;
    end
  end

  always_comb begin
    res_max_d = '0;
    res_id_d  = '0;
    for (int l = 0; l < LANES; l++) begin
      nxt_max[l] = run_max[l];
      nxt_id[l]  = run_id[l];
      if (stage_o == SW'(ARGMAX_STAGE) && fp_gt(bus.value_i[l*WIDTH +: WIDTH], run_max[l])) begin
        nxt_max[l] = bus.value_i[l*WIDTH +: WIDTH];
        nxt_id[l]  = bus.pos_i[l*ID_W +: ID_W];
      end
      if (stage_o == SW'(SELECT_STAGE)) begin
        if (fp_gt(nxt_max[l], THRESH)) begin
          res_max_d[l*WIDTH +: WIDTH] = nxt_max[l];
          res_id_d[l*ID_W +: ID_W]    = nxt_id[l];
        end else begin
          res_max_d[l*WIDTH +: WIDTH] = FP_ONE;
          res_id_d[l*ID_W +: ID_W]    = NULL_V;
        end
      end else begin
        res_max_d[l*WIDTH +: WIDTH] = nxt_max[l];
        res_id_d[l*ID_W +: ID_W]    = nxt_id[l];
      end
    end
  end

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      step             <= '0;
      stage_o          <= '0;
      bus.out_valid_o  <= 1'b0;
      bus.value_o      <= '0;
      bus.result_id_o  <= '0;
      bus.result_max_o <= '0;
      bus.beat_stage_o <= '0;
      for (int l = 0; l < LANES; l++) begin
        run_max[l] <= NEG_INF;
        run_id[l]  <= NULL_V;
      end
    end else if (accept) begin
      step             <= (&step) ? step : step + 1'b1;
      stage_o          <= stage_next;
      bus.out_valid_o  <= 1'b1;
      bus.value_o      <= bus.value_i;
      bus.result_id_o  <= res_id_d;
      bus.result_max_o <= res_max_d;
      bus.beat_stage_o <= stage_o;
      for (int l = 0; l < LANES; l++) begin
        run_max[l] <= nxt_max[l];
        run_id[l]  <= nxt_id[l];
      end
    end else if (bus.out_ready_i) begin
      bus.out_valid_o <= 1'b0;
    end
  end

endmodule
